// File: rtl/activation_writeback.sv
// Activation result writeback: snapshots the activation lane bus on ready, saturates
// each lane to 16 bits and streams the lanes one per cycle into a 16-bit BRAM port.
module activation_writeback #(
    parameter int MAX_WORD_LENGTH = 32,
    parameter int LANES           = 100
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [9:0]                         base_addr,
    input  logic [7:0]                         lane_cnt,
    input  logic [0:LANES*MAX_WORD_LENGTH-1]   data_in,
    input  logic [0:LANES-1]                   ready_in,
    input  logic                               wr_hold,
    output logic                               we,
    output logic [9:0]                         addr,
    output logic [15:0]                        dout,
    output logic                               busy,
    output logic                               done,
    output logic                               sat_flag
);

    localparam int W = MAX_WORD_LENGTH;
    localparam logic signed [W-1:0] SAT_MAX = W'(32767);
    localparam logic signed [W-1:0] SAT_MIN = W'(-32768);

    typedef enum logic [1:0] {IDLE, ARM, WRITE, DONE} state_t;

    state_t              state;
    logic [9:0]          base_q;
    logic [7:0]          n_q;
    logic [7:0]          k_q;
    logic [0:LANES*W-1]  snap_q;

    logic signed [W-1:0] lane_val;
    logic [15:0]         lane_sat;
    logic                lane_clamped;
    logic [7:0]          n_eff;
    logic                unused_ready;

    // Only lane 0's ready flag matters; the other lanes finish in lockstep with it.
    assign unused_ready = ^ready_in[1:LANES-1];

    assign n_eff = (lane_cnt == 8'd0 || lane_cnt > 8'(LANES)) ? 8'(LANES) : lane_cnt;

    // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
    always_comb begin
        lane_val     = snap_q[int'(k_q)*W +: W];
        lane_sat     = lane_val[15:0];
        lane_clamped = 1'b0;
        if (lane_val > SAT_MAX) begin
            lane_sat     = 16'h7FFF;
            lane_clamped = 1'b1;
        end else if (lane_val < SAT_MIN) begin
            lane_sat     = 16'h8000;
            lane_clamped = 1'b1;
        end
    end

    // NOTE: the snapshot is pure datapath storage, always loaded before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        if (state == ARM && ready_in[0]) begin
            snap_q <= data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            we       <= 1'b0;
            addr     <= 10'd0;
            dout     <= 16'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            k_q      <= 8'd0;
            base_q   <= 10'd0;
            n_q      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    we   <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        base_q   <= base_addr;
                        n_q      <= n_eff;
                        sat_flag <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    if (ready_in[0]) begin
                        k_q   <= 8'd0;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_hold) begin
                        we <= 1'b0;
                    end else begin
                        we   <= 1'b1;
                        addr <= base_q + 10'(k_q);
                        dout <= lane_sat;
                        if (lane_clamped) begin
                            sat_flag <= 1'b1;
                        end
                        k_q <= k_q + 8'd1;
                        if (k_q == n_q - 8'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    we    <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_writeback.sv
// Self-checking bench for activation_writeback: directed corner cases plus randomized
// transfers, each compared against an expected write list built from the lane values.
module tb_activation_writeback;

    localparam int W     = 32;
    localparam int LANES = 100;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [9:0]             base_addr;
    logic [7:0]             lane_cnt;
    logic [0:LANES*W-1]     data_in;
    logic [0:LANES-1]       ready_in;
    logic                   wr_hold;
    logic                   we;
    logic [9:0]             addr;
    logic [15:0]            dout;
    logic                   busy;
    logic                   done;
    logic                   sat_flag;

    int checks = 0;
    int errors = 0;
    logic signed [W-1:0] lanes [LANES];

    activation_writeback #(.MAX_WORD_LENGTH(W), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .lane_cnt(lane_cnt), .data_in(data_in), .ready_in(ready_in),
        .wr_hold(wr_hold), .we(we), .addr(addr), .dout(dout),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference saturation: plain integer comparison against the 16-bit signed range.
    function automatic logic [15:0] ref_sat(input logic signed [W-1:0] v);
        longint x;
        x = v;
        if (x > 32767)  return 16'h7FFF;
        if (x < -32768) return 16'h8000;
        return 16'(x);
    endfunction

    function automatic bit ref_clamps(input logic signed [W-1:0] v);
        longint x;
        x = v;
        return (x > 32767) || (x < -32768);
    endfunction

    task automatic randomize_lanes();
        for (int k = 0; k < LANES; k++) begin
            case ($urandom_range(0, 3))
                0: lanes[k] = W'($urandom_range(0, 65535)) - 32'sd32768;
                1: lanes[k] = $urandom;
                2: begin
                    case ($urandom_range(0, 3))
                        0: lanes[k] = 32'sd32767;
                        1: lanes[k] = 32'sd32768;
                        2: lanes[k] = -32'sd32768;
                        default: lanes[k] = -32'sd32769;
                    endcase
                end
                default: lanes[k] = W'($urandom_range(0, 200)) - 32'sd100;
            endcase
        end
    endtask

    // hold_mode: 0 none, 1 random, 2 three holds on lane 1. abort_at: lane index at
    // which reset is pulled instead of writing (-1 = never).
    task automatic run_xfer(input logic [9:0] base, input logic [7:0] cnt, input int ready_delay,
                            input int hold_mode, input int abort_at, input bit mid_start,
                            input bit idle_ready);
        int n;
        int idx;
        int held;
        int budget;
        bit hold;
        bit esat;
        logic [9:0]  ea[$];
        logic [15:0] ed[$];

        n = (cnt == 0 || int'(cnt) > LANES) ? LANES : int'(cnt);
        esat = 1'b0;
        for (int i = 0; i < n; i++) begin
            ea.push_back(10'((int'(base) + i) % 1024));
            ed.push_back(ref_sat(lanes[i]));
            if (ref_clamps(lanes[i])) esat = 1'b1;
        end
        for (int k = 0; k < LANES; k++) data_in[k*W +: W] = lanes[k];

        if (idle_ready) begin
            @(negedge clk); ready_in[0] = 1'b1;
            @(negedge clk); ready_in[0] = 1'b0;
            check("idle_ready_no_busy", 32'(busy), 32'd0);
        end

        @(negedge clk);
        start = 1'b1; base_addr = base; lane_cnt = cnt;
        @(negedge clk);
        start = 1'b0; base_addr = 10'($urandom); lane_cnt = 8'($urandom);
        check("start_busy", 32'(busy), 32'd1);
        check("start_sat_clear", 32'(sat_flag), 32'd0);
        check("start_we", 32'(we), 32'd0);

        for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk);
            check("arm_we", 32'(we), 32'd0);
            check("arm_busy", 32'(busy), 32'd1);
        end

        ready_in = LANES'({$urandom, $urandom, $urandom, $urandom});
        ready_in[0] = 1'b1;
        @(negedge clk);
        ready_in = '0;
        for (int k = 0; k < LANES; k++) data_in[k*W +: W] = $urandom;

        idx = 0; held = 0; budget = 0;
        while (idx < n && budget < 2000) begin
            budget++;
            if (idx == abort_at) break;
            case (hold_mode)
                1:       hold = ($urandom_range(0, 3) == 0);
                2:       hold = (idx == 1 && held < 3);
                default: hold = 1'b0;
            endcase
            if (hold) held++;
            wr_hold = hold;
            if (mid_start && idx == n / 2) begin
                start = 1'b1; base_addr = 10'($urandom); lane_cnt = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("write_busy", 32'(busy), 32'd1);
            if (hold) begin
                check("hold_we", 32'(we), 32'd0);
                if (idx > 0) begin
                    check("hold_addr", 32'(addr), 32'(ea[idx-1]));
                    check("hold_dout", 32'(dout), 32'(ed[idx-1]));
                end
            end else begin
                check("write_we", 32'(we), 32'd1);
                check("write_addr", 32'(addr), 32'(ea[idx]));
                check("write_dout", 32'(dout), 32'(ed[idx]));
                idx++;
            end
        end
        wr_hold = 1'b0;
        start   = 1'b0;

        if (abort_at >= 0) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            check("abort_we", 32'(we), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_addr", 32'(addr), 32'd0);
            check("abort_sat", 32'(sat_flag), 32'd0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("post_abort_we", 32'(we), 32'd0);
                check("post_abort_done", 32'(done), 32'd0);
                check("post_abort_busy", 32'(busy), 32'd0);
            end
            return;
        end

        check("lanes_written", 32'(idx), 32'(n));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_we", 32'(we), 32'd0);
        check("done_sat", 32'(sat_flag), 32'(esat));
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("idle_we", 32'(we), 32'd0);
        check("sat_sticky", 32'(sat_flag), 32'(esat));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; wr_hold = 1'b0;
        base_addr = 10'd0; lane_cnt = 8'd0;
        data_in = '0; ready_in = '0;
        for (int k = 0; k < LANES; k++) lanes[k] = 32'sd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        reset = 1'b1;

        // Small signed values pass through unchanged.
        randomize_lanes();
        lanes[0] = 32'sd1; lanes[1] = -32'sd1; lanes[2] = 32'sd2; lanes[3] = -32'sd2;
        run_xfer(10'd0, 8'd4, 0, 0, -1, 1'b0, 1'b0);

        // Positive and negative saturation.
        randomize_lanes();
        lanes[0] = 32'sh0001_0000; lanes[1] = 32'shFFFF_0000;
        run_xfer(10'd37, 8'd2, 1, 0, -1, 1'b0, 1'b0);

        // sat_flag cleared by the next start; ready seen in IDLE is not remembered.
        randomize_lanes();
        for (int k = 0; k < 4; k++) lanes[k] = W'(k * 100);
        run_xfer(10'd500, 8'd4, 3, 0, -1, 1'b0, 1'b1);

        // Address wraps past 1023.
        randomize_lanes();
        run_xfer(10'd1022, 8'd4, 0, 0, -1, 1'b0, 1'b0);

        // Three hold cycles on lane 1.
        randomize_lanes();
        run_xfer(10'd100, 8'd4, 0, 2, -1, 1'b0, 1'b0);

        // lane_cnt 0 means all lanes; a start mid-transfer is ignored.
        randomize_lanes();
        run_xfer(10'd900, 8'd0, 2, 0, -1, 1'b1, 1'b0);

        // lane_cnt above LANES is clamped.
        randomize_lanes();
        run_xfer(10'd5, 8'd200, 0, 1, -1, 1'b0, 1'b0);

        // Reset during lane 5, then a clean transfer.
        randomize_lanes();
        run_xfer(10'd300, 8'd20, 0, 0, 5, 1'b0, 1'b0);
        randomize_lanes();
        run_xfer(10'd300, 8'd20, 1, 0, -1, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            randomize_lanes();
            run_xfer(10'($urandom), 8'($urandom), $urandom_range(0, 3), 1, -1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
